pcie_rx_symbol_demux: RTL and testbench
=======================================

# pcie_rx_symbol_demux

Receive-side symbol demultiplexer for the PCIe physical layer. It accepts the byte stream and K flag from the 8b/10b decoder and strips framing K-codes (STP, SDP, END, EDB, PAD, COM, SKP, FTS, IDL). It delivers packet payload bytes with start, end and abort strobes, and flags ordered sets and framing errors. It is the receive counterpart of the transmit K-code insertion mux and uses the same symbol values and the same 4-bit symbol-code numbering.

## Interface
- MAX_LEN, 1024: maximum payload bytes between STP/SDP and END/EDB; must be ≤ 4095.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-high.
- data_in  in  8  decoded byte.
- k_in  in  1  1 = data_in is a K-code.
- valid_in  in  1  data_in/k_in are valid this cycle.
- data_out  out  8  payload byte (registered).
- data_valid  out  1  data_out carries a payload byte.
- sym_code  out  4  classification of the last valid input: 0 data, 1 COM, 2 PAD, 3 SKP, 4 STP, 5 SDP, 6 END, 7 EDB, 8 FTS, 9 IDL, 15 unknown K.
- pkt_start  out  1  one-cycle strobe; STP or SDP accepted.
- pkt_type  out  1  0 = TLP (STP), 1 = DLLP (SDP); updated with pkt_start.
- pkt_end  out  1  one-cycle strobe; END closed a good packet.
- pkt_abort  out  1  one-cycle strobe; packet discarded.
- pkt_len  out  12  payload byte count; valid with pkt_end or pkt_abort.
- skp_os, fts_os, idl_os  out  1 each  one-cycle strobe on recognition of COM+SKP, COM+FTS or COM+IDL.
- skp_count  out  3  number of SKP symbols in the last SKP ordered set, saturating at 7.
- err  out  1  one-cycle strobe on any framing violation.

## Operation
- K-code values: COM BC, PAD F7, SKP 1C, STP FB, SDP 5C, END FD, EDB FE, FTS 3C, IDL 7C. Any other byte with k_in=1 is unknown: sym_code=15.
- States: IDLE, TLP, DLLP, OS_HDR, OS_BODY. Transitions occur only on valid_in=1. With valid_in=0, state, counters and data_out hold, and all strobes and data_valid are 0.
- IDLE:
  - Data bytes are logical idle and are dropped silently.
  - PAD is ignored.
  - STP: go to TLP; pkt_start=1, pkt_type=0, len=0.
  - SDP: go to DLLP; pkt_start=1, pkt_type=1, len=0.
  - COM: go to OS_HDR.
  - END, EDB, SKP, FTS, IDL or unknown K: err=1, stay in IDLE.
- TLP/DLLP:
  - Data byte: data_out=byte, data_valid=1, len++.
  - If len is already MAX_LEN when a data byte arrives: err=1, pkt_abort=1, go to IDLE; the byte is not output.
  - END with len≥1: pkt_end=1, go to IDLE.
  - END with len=0: err=1, pkt_abort=1, go to IDLE.
  - EDB: pkt_abort=1, go to IDLE; no err.
  - Any other K (STP, SDP, COM, PAD, SKP, FTS, IDL, unknown): err=1 and pkt_abort=1 in the same cycle. The symbol is then processed as in IDLE in that same cycle, so STP/SDP also raise pkt_start and COM enters OS_HDR.
- OS_HDR:
  - SKP: skp_os=1, skp_count=1, go to OS_BODY(SKP).
  - FTS: fts_os=1, go to OS_BODY(FTS).
  - IDL: idl_os=1, go to OS_BODY(IDL).
  - Anything else: err=1, go to IDLE.
- OS_BODY:
  - Repeats of the same K-code are consumed; for SKP, skp_count increments and saturates at 7.
  - Any other symbol ends the ordered set and is processed as in IDLE in that same cycle.
- pkt_len holds its value until the next pkt_start.

## Timing
- All outputs are registered. The response to a symbol sampled at edge N is visible after edge N, so latency is 1 cycle.
- Reset values: state IDLE; data_out 0; sym_code 0; pkt_type 0; pkt_len 0; skp_count 0; all strobes, data_valid and err 0.
- Reset mid-packet discards the packet immediately, with no pkt_abort strobe.
- Throughput is one symbol per cycle with no back-pressure.
- pkt_end and pkt_abort never assert in the same cycle.
- pkt_abort and pkt_start may coincide in the same cycle; this is the STP-inside-packet case.

## Test plan
- STP, 3 data bytes (11,22,33), END → pkt_start with pkt_type=0; data_valid for 3 cycles carrying 11,22,33; then pkt_end with pkt_len=3 and no err.
- SDP, 6 data bytes, EDB → pkt_type=1, 6 data_valid cycles, then pkt_abort with pkt_len=6; err stays 0.
- COM, SKP, SKP, SKP, STP → skp_os asserts once, skp_count=3, then pkt_start on the STP cycle with no err.
- STP, 2 data bytes, SDP, 1 data byte, END → on the SDP cycle err=1, pkt_abort=1 with pkt_len=2, and pkt_start=1 with pkt_type=1; then pkt_end with pkt_len=1.
- MAX_LEN=4: STP plus 5 data bytes → 4 data_valid cycles, then on the 5th byte err=1, pkt_abort=1, pkt_len=4, and the state returns to IDLE.
- Sequence END in IDLE, unknown K 0xAA, COM followed by data 00, and valid_in gaps inserted mid-packet → err on each violation; sym_code=15 for 0xAA; no change in state or outputs during the valid_in=0 gaps.

Source files
------------

// File: rtl/pcie_rx_symbol_demux_if.sv
// rtl/pcie_rx_symbol_demux_if.sv - symbol input and payload/strobe output bundle for the rx symbol demux
interface pcie_rx_symbol_demux_if;
    logic [7:0]  data_in;
    logic        k_in;
    logic        valid_in;
    logic [7:0]  data_out;
    logic        data_valid;
    logic [3:0]  sym_code;
    logic        pkt_start;
    logic        pkt_type;
    logic        pkt_end;
    logic        pkt_abort;
    logic [11:0] pkt_len;
    logic        skp_os;
    logic        fts_os;
    logic        idl_os;
    logic [2:0]  skp_count;
    logic        err;

    modport master (
        output data_in, k_in, valid_in,
        input  data_out, data_valid, sym_code, pkt_start, pkt_type, pkt_end,
               pkt_abort, pkt_len, skp_os, fts_os, idl_os, skp_count, err
    );

    modport slave (
        input  data_in, k_in, valid_in,
        output data_out, data_valid, sym_code, pkt_start, pkt_type, pkt_end,
               pkt_abort, pkt_len, skp_os, fts_os, idl_os, skp_count, err
    );
endinterface

// File: rtl/pcie_rx_symbol_demux.sv
// rtl/pcie_rx_symbol_demux.sv - strips PCIe framing K-codes and emits payload bytes, packet and ordered-set strobes
module pcie_rx_symbol_demux #(
    parameter int MAX_LEN = 1024
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    pcie_rx_symbol_demux_if.slave  bus
);

    localparam logic [11:0] MAX_LEN_C = MAX_LEN[11:0];

    localparam logic [3:0] C_DATA = 4'd0;
    localparam logic [3:0] C_COM  = 4'd1;
    localparam logic [3:0] C_PAD  = 4'd2;
    localparam logic [3:0] C_SKP  = 4'd3;
    localparam logic [3:0] C_STP  = 4'd4;
    localparam logic [3:0] C_SDP  = 4'd5;
    localparam logic [3:0] C_END  = 4'd6;
    localparam logic [3:0] C_EDB  = 4'd7;
    localparam logic [3:0] C_FTS  = 4'd8;
    localparam logic [3:0] C_IDL  = 4'd9;
    localparam logic [3:0] C_UNK  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TLP,
        S_DLLP,
        S_OS_HDR,
        S_OS_BODY
    } state_t;

    state_t      state_q;
    logic [3:0]  os_code_q;
    logic [11:0] len_q;
    logic [7:0]  data_out_q;
    logic        data_valid_q;
    logic [3:0]  sym_code_q;
    logic        pkt_start_q;
    logic        pkt_type_q;
    logic        pkt_end_q;
    logic        pkt_abort_q;
    logic [11:0] pkt_len_q;
    logic        skp_os_q;
    logic        fts_os_q;
    logic        idl_os_q;
    logic [2:0]  skp_count_q;
    logic        err_q;

    logic [3:0]  sym_c;
    state_t      idle_state_d;
    logic        idle_start;
    logic        idle_type;
    logic        idle_err;
    logic        in_pkt;
    logic        route_idle;

    // Classify the incoming symbol into the shared 4-bit symbol-code numbering
    always_comb begin
        sym_c = C_DATA;
        if (bus.k_in) begin
            case (bus.data_in)
                8'hBC:   sym_c = C_COM;
                8'hF7:   sym_c = C_PAD;
                8'h1C:   sym_c = C_SKP;
                8'hFB:   sym_c = C_STP;
                8'h5C:   sym_c = C_SDP;
                8'hFD:   sym_c = C_END;
                8'hFE:   sym_c = C_EDB;
                8'h3C:   sym_c = C_FTS;
                8'h7C:   sym_c = C_IDL;
                default: sym_c = C_UNK;
            endcase
        end
    end

    // How the symbol would be handled from IDLE; reused when a packet or ordered set is cut short
    always_comb begin
        idle_state_d = S_IDLE;
        idle_start   = 1'b0;
        idle_type    = 1'b0;
        idle_err     = 1'b0;
        case (sym_c)
            C_DATA, C_PAD: ;
            C_STP: begin
                idle_state_d = S_TLP;
                idle_start   = 1'b1;
            end
            C_SDP: begin
                idle_state_d = S_DLLP;
                idle_start   = 1'b1;
                idle_type    = 1'b1;
            end
            C_COM:   idle_state_d = S_OS_HDR;
            default: idle_err     = 1'b1;
        endcase
    end

    // Decide whether this symbol falls through to the IDLE handling in the same cycle
    always_comb begin
        in_pkt     = (state_q == S_TLP) || (state_q == S_DLLP);
        route_idle = (state_q == S_IDLE)
                   || ((state_q == S_OS_BODY) && (sym_c != os_code_q))
                   || (in_pkt && bus.k_in && (sym_c != C_END) && (sym_c != C_EDB));
    end

    // Main FSM: all outputs registered, strobes single-cycle, everything holds when valid_in is low
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            os_code_q    <= C_DATA;
            len_q        <= 12'd0;
            data_out_q   <= 8'd0;
            data_valid_q <= 1'b0;
            sym_code_q   <= 4'd0;
            pkt_start_q  <= 1'b0;
            pkt_type_q   <= 1'b0;
            pkt_end_q    <= 1'b0;
            pkt_abort_q  <= 1'b0;
            pkt_len_q    <= 12'd0;
            skp_os_q     <= 1'b0;
            fts_os_q     <= 1'b0;
            idl_os_q     <= 1'b0;
            skp_count_q  <= 3'd0;
            err_q        <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            pkt_start_q  <= 1'b0;
            pkt_end_q    <= 1'b0;
            pkt_abort_q  <= 1'b0;
            skp_os_q     <= 1'b0;
            fts_os_q     <= 1'b0;
            idl_os_q     <= 1'b0;
            err_q        <= 1'b0;
            if (bus.valid_in) begin
                sym_code_q <= sym_c;
                case (state_q)
                    S_TLP, S_DLLP: begin
                        if (!bus.k_in) begin
                            if (len_q == MAX_LEN_C) begin
                                err_q       <= 1'b1;
                                pkt_abort_q <= 1'b1;
                                pkt_len_q   <= len_q;
                                state_q     <= S_IDLE;
                            end else begin
                                data_out_q   <= bus.data_in;
                                data_valid_q <= 1'b1;
                                len_q        <= len_q + 12'd1;
                            end
                        end else if (sym_c == C_END) begin
                            if (len_q != 12'd0) begin
                                pkt_end_q   <= 1'b1;
                            end else begin
                                err_q       <= 1'b1;
                                pkt_abort_q <= 1'b1;
                            end
                            pkt_len_q <= len_q;
                            state_q   <= S_IDLE;
                        end else if (sym_c == C_EDB) begin
                            pkt_abort_q <= 1'b1;
                            pkt_len_q   <= len_q;
                            state_q     <= S_IDLE;
                        end else begin
                            // Stray K-code inside a packet: abort here, then re-handle as IDLE below
                            err_q       <= 1'b1;
                            pkt_abort_q <= 1'b1;
                            pkt_len_q   <= len_q;
                        end
                    end
                    S_OS_HDR: begin
                        os_code_q <= sym_c;
                        state_q   <= S_OS_BODY;
                        case (sym_c)
                            C_SKP: begin
                                skp_os_q    <= 1'b1;
                                skp_count_q <= 3'd1;
                            end
                            C_FTS: fts_os_q <= 1'b1;
                            C_IDL: idl_os_q <= 1'b1;
                            default: begin
                                err_q   <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                    S_OS_BODY: begin
                        if ((sym_c == os_code_q) && (sym_c == C_SKP) && (skp_count_q != 3'd7)) begin
                            skp_count_q <= skp_count_q + 3'd1;
                        end
                    end
                    default: ;
                endcase
                // IDLE-style handling; later assignments here take precedence over the case above
                if (route_idle) begin
                    state_q     <= idle_state_d;
                    pkt_start_q <= idle_start;
                    if (idle_start) begin
                        pkt_type_q <= idle_type;
                        len_q      <= 12'd0;
                        if (!in_pkt) begin
                            pkt_len_q <= 12'd0;
                        end
                    end
                    if (idle_err) begin
                        err_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.sym_code   = sym_code_q;
    assign bus.pkt_start  = pkt_start_q;
    assign bus.pkt_type   = pkt_type_q;
    assign bus.pkt_end    = pkt_end_q;
    assign bus.pkt_abort  = pkt_abort_q;
    assign bus.pkt_len    = pkt_len_q;
    assign bus.skp_os     = skp_os_q;
    assign bus.fts_os     = fts_os_q;
    assign bus.idl_os     = idl_os_q;
    assign bus.skp_count  = skp_count_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_pcie_rx_symbol_demux.sv
// tb/tb_pcie_rx_symbol_demux.sv - directed scoreboard bench for pcie_rx_symbol_demux
module tb_pcie_rx_symbol_demux;

    localparam logic [7:0] DV = 8'h80;
    localparam logic [7:0] ST = 8'h40;
    localparam logic [7:0] EN = 8'h20;
    localparam logic [7:0] AB = 8'h10;
    localparam logic [7:0] SK = 8'h08;
    localparam logic [7:0] FT = 8'h04;
    localparam logic [7:0] ID = 8'h02;
    localparam logic [7:0] ER = 8'h01;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d_in = 8'h00;
    logic       k_in = 1'b0;
    logic       v_in = 1'b0;
    logic       chk4 = 1'b0;

    logic [7:0]  e_dout = 8'h00;
    logic [3:0]  e_code = 4'h0;
    logic        e_type = 1'b0;
    logic [11:0] e_len  = 12'd0;
    logic [2:0]  e_skpc = 3'd0;

    int checks = 0;
    int errors = 0;
    int step   = 0;
    logic [35:0] sb[$];
    logic [35:0] obs1;
    logic [35:0] obs4;

    always #5 clk = ~clk;

    pcie_rx_symbol_demux_if bus();
    pcie_rx_symbol_demux_if bus4();

    assign bus.data_in   = d_in;
    assign bus.k_in      = k_in;
    assign bus.valid_in  = v_in;
    assign bus4.data_in  = d_in;
    assign bus4.k_in     = k_in;
    assign bus4.valid_in = v_in;

    pcie_rx_symbol_demux #(.MAX_LEN(1024)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    pcie_rx_symbol_demux #(.MAX_LEN(4)) dut4 (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus4.slave)
    );

    assign obs1 = {bus.data_out, bus.data_valid, bus.sym_code, bus.pkt_start, bus.pkt_type,
                   bus.pkt_end, bus.pkt_abort, bus.pkt_len, bus.skp_os, bus.fts_os,
                   bus.idl_os, bus.skp_count, bus.err};
    assign obs4 = {bus4.data_out, bus4.data_valid, bus4.sym_code, bus4.pkt_start, bus4.pkt_type,
                   bus4.pkt_end, bus4.pkt_abort, bus4.pkt_len, bus4.skp_os, bus4.fts_os,
                   bus4.idl_os, bus4.skp_count, bus4.err};

    function automatic logic [35:0] pack(input logic [7:0] st);
        return {e_dout, st[7], e_code, st[6], e_type, st[5], st[4], e_len,
                st[3], st[2], st[1], e_skpc, st[0]};
    endfunction

    task automatic compare();
        logic [35:0] e;
        logic [35:0] o;
        e = sb.pop_front();
        o = chk4 ? obs4 : obs1;
        step++;
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL step%0d dut%0s: observed %h expected %h", step, chk4 ? "4" : "", o, e);
        end
    endtask

    task automatic sym(input logic k, input logic [7:0] d, input logic [7:0] st, input logic [3:0] c);
        k_in   = k;
        d_in   = d;
        v_in   = 1'b1;
        e_code = c;
        sb.push_back(pack(st));
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic dat(input logic [7:0] d);
        e_dout = d;
        sym(1'b0, d, DV, 4'd0);
    endtask

    task automatic gap();
        k_in = 1'b1;
        d_in = 8'hEE;
        v_in = 1'b0;
        sb.push_back(pack(8'h00));
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        v_in   = 1'b0;
        e_dout = 8'h00;
        e_code = 4'h0;
        e_type = 1'b0;
        e_len  = 12'd0;
        e_skpc = 3'd0;
        @(posedge clk);
        #1;
        sb.push_back(pack(8'h00));
        compare();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // STP 11 22 33 END
        e_type = 1'b0; e_len = 12'd0;
        sym(1'b1, 8'hFB, ST, 4'd4);
        dat(8'h11); dat(8'h22); dat(8'h33);
        e_len = 12'd3;
        sym(1'b1, 8'hFD, EN, 4'd6);

        // SDP, 6 bytes, EDB
        e_type = 1'b1; e_len = 12'd0;
        sym(1'b1, 8'h5C, ST, 4'd5);
        for (int i = 0; i < 6; i++) dat(8'h40 + 8'(i));
        e_len = 12'd6;
        sym(1'b1, 8'hFE, AB, 4'd7);

        // COM SKP SKP SKP then STP
        sym(1'b1, 8'hBC, 8'h00, 4'd1);
        e_skpc = 3'd1; sym(1'b1, 8'h1C, SK, 4'd3);
        e_skpc = 3'd2; sym(1'b1, 8'h1C, 8'h00, 4'd3);
        e_skpc = 3'd3; sym(1'b1, 8'h1C, 8'h00, 4'd3);
        e_type = 1'b0; e_len = 12'd0;
        sym(1'b1, 8'hFB, ST, 4'd4);
        dat(8'h55);
        e_len = 12'd1;
        sym(1'b1, 8'hFD, EN, 4'd6);

        // STP inside a packet: SDP aborts the TLP and opens a DLLP
        e_type = 1'b0; e_len = 12'd0;
        sym(1'b1, 8'hFB, ST, 4'd4);
        dat(8'hA1); dat(8'hA2);
        e_type = 1'b1; e_len = 12'd2;
        sym(1'b1, 8'h5C, ST | AB | ER, 4'd5);
        dat(8'hB1);
        e_len = 12'd1;
        sym(1'b1, 8'hFD, EN, 4'd6);

        // Violations in IDLE and OS_HDR
        sym(1'b1, 8'hFD, ER, 4'd6);
        sym(1'b1, 8'hAA, ER, 4'd15);
        sym(1'b1, 8'hBC, 8'h00, 4'd1);
        sym(1'b0, 8'h00, ER, 4'd0);
        sym(1'b1, 8'hF7, 8'h00, 4'd2);
        sym(1'b0, 8'h12, 8'h00, 4'd0);

        // Packet with valid_in gaps
        e_type = 1'b0; e_len = 12'd0;
        sym(1'b1, 8'hFB, ST, 4'd4);
        dat(8'h11);
        gap(); gap();
        dat(8'h22);
        gap();
        e_len = 12'd2;
        sym(1'b1, 8'hFD, EN, 4'd6);

        // END with zero payload
        e_len = 12'd0;
        sym(1'b1, 8'hFB, ST, 4'd4);
        sym(1'b1, 8'hFD, AB | ER, 4'd6);

        // FTS and IDL ordered sets
        sym(1'b1, 8'hBC, 8'h00, 4'd1);
        sym(1'b1, 8'h3C, FT, 4'd8);
        sym(1'b1, 8'h3C, 8'h00, 4'd8);
        sym(1'b1, 8'h7C, ER, 4'd9);
        sym(1'b1, 8'hBC, 8'h00, 4'd1);
        sym(1'b1, 8'h7C, ID, 4'd9);
        sym(1'b0, 8'h00, 8'h00, 4'd0);

        // SKP count saturation at 7
        sym(1'b1, 8'hBC, 8'h00, 4'd1);
        e_skpc = 3'd1; sym(1'b1, 8'h1C, SK, 4'd3);
        for (int i = 2; i <= 9; i++) begin
            e_skpc = (i > 7) ? 3'd7 : 3'(i);
            sym(1'b1, 8'h1C, 8'h00, 4'd3);
        end
        sym(1'b0, 8'h00, 8'h00, 4'd0);

        // Reset mid-packet: no abort, next data is idle
        sym(1'b1, 8'hFB, ST, 4'd4);
        dat(8'h66);
        do_reset();
        sym(1'b0, 8'h77, 8'h00, 4'd0);

        // MAX_LEN=4 overflow on the second instance
        do_reset();
        chk4 = 1'b1;
        e_type = 1'b0; e_len = 12'd0;
        sym(1'b1, 8'hFB, ST, 4'd4);
        for (int i = 1; i <= 4; i++) dat(8'(i));
        e_len = 12'd4;
        sym(1'b0, 8'h05, AB | ER, 4'd0);
        sym(1'b0, 8'h06, 8'h00, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
